// File: rtl/wired_fetch_queue.sv
// Instruction fetch queue: compacts valid slots of 2-wide fetch packets into a
// circular buffer and presents the two oldest instructions to decode each cycle.
package wired_fetch_queue_pkg;
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } bpu_predict_t;
endpackage

module wired_fetch_queue
    import wired_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                f_valid_i,
    output logic                f_ready_o,
    input  logic [31:0]         f_pc_i,
    input  logic [1:0]          f_mask_i,
    input  logic [1:0][31:0]    f_inst_i,
    input  bpu_predict_t [1:0]  f_predict_i,
    output logic [1:0]          d_valid_o,
    input  logic [1:0]          d_ready_i,
    output logic [1:0][31:0]    d_pc_o,
    output logic [1:0][31:0]    d_inst_o,
    output bpu_predict_t [1:0]  d_predict_o
);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rptr1, wptr1;

    logic [31:0]  pc_mem   [DEPTH];
    logic [31:0]  inst_mem [DEPTH];
    bpu_predict_t pred_mem [DEPTH];

    logic         acc;
    logic [1:0]   n_in, n_out;
    logic         we0, we1;
    logic [31:0]  wr0_pc, wr1_pc, wr0_inst, wr1_inst;
    bpu_predict_t wr0_pred, wr1_pred;

    // Ready only looks at the registered count so it never depends on d_ready_i.
    assign f_ready_o = !flush_i && (count_q <= CNT_W'(DEPTH - 2));
    assign acc       = f_valid_i && f_ready_o;
    assign n_in      = {1'b0, f_mask_i[0]} + {1'b0, f_mask_i[1]};

    assign wptr1 = wptr_q + PTR_W'(1);
    assign rptr1 = rptr_q + PTR_W'(1);

    // Compaction: the first write port takes slot1 when slot0 is masked off.
    assign we0      = acc && (f_mask_i != 2'b00);
    assign we1      = acc && (f_mask_i == 2'b11);
    assign wr0_pc   = f_mask_i[0] ? {f_pc_i[31:3], 3'b000} : {f_pc_i[31:3], 3'b100};
    assign wr0_inst = f_mask_i[0] ? f_inst_i[0] : f_inst_i[1];
    assign wr0_pred = f_mask_i[0] ? f_predict_i[0] : f_predict_i[1];
    assign wr1_pc   = {f_pc_i[31:3], 3'b100};
    assign wr1_inst = f_inst_i[1];
    assign wr1_pred = f_predict_i[1];

    always_ff @(posedge clk) begin
        if (we0) begin
            pc_mem[wptr_q]   <= wr0_pc;
            inst_mem[wptr_q] <= wr0_inst;
            pred_mem[wptr_q] <= wr0_pred;
        end
        if (we1) begin
            pc_mem[wptr1]   <= wr1_pc;
            inst_mem[wptr1] <= wr1_inst;
            pred_mem[wptr1] <= wr1_pred;
        end
    end

    assign d_valid_o[0] = (count_q != '0);
    assign d_valid_o[1] = (count_q >= CNT_W'(2));

    assign d_pc_o[0]      = pc_mem[rptr_q];
    assign d_pc_o[1]      = pc_mem[rptr1];
    assign d_inst_o[0]    = inst_mem[rptr_q];
    assign d_inst_o[1]    = inst_mem[rptr1];
    assign d_predict_o[0] = pred_mem[rptr_q];
    assign d_predict_o[1] = pred_mem[rptr1];

    // Slot1 only retires together with slot0 to keep decode in order.
    assign n_out = {1'b0, d_valid_o[0] & d_ready_i[0]}
                 + {1'b0, d_valid_o[1] & d_ready_i[1] & d_ready_i[0]};

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (acc) begin
                wptr_d = wptr_q + PTR_W'(n_in);
            end
            rptr_d  = rptr_q + PTR_W'(n_out);
            count_d = count_q + CNT_W'(acc ? n_in : 2'd0) - CNT_W'(n_out);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_valid_therm: assert property (@(posedge clk) disable iff (!rst_n)
        d_valid_o != 2'b10);
`endif

endmodule

// File: tb/tb_wired_fetch_queue.sv
// Bench for wired_fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based model of the instruction stream.
module tb_wired_fetch_queue;
    import wired_fetch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush_i = 1'b0;
    logic               f_valid_i = 1'b0;
    logic               f_ready_o;
    logic [31:0]        f_pc_i = '0;
    logic [1:0]         f_mask_i = '0;
    logic [1:0][31:0]   f_inst_i = '0;
    bpu_predict_t [1:0] f_predict_i = '0;
    logic [1:0]         d_valid_o;
    logic [1:0]         d_ready_i = '0;
    logic [1:0][31:0]   d_pc_o;
    logic [1:0][31:0]   d_inst_o;
    bpu_predict_t [1:0] d_predict_o;

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  inst;
        bpu_predict_t pred;
    } ent_t;

    ent_t mq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wired_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .f_valid_i  (f_valid_i),
        .f_ready_o  (f_ready_o),
        .f_pc_i     (f_pc_i),
        .f_mask_i   (f_mask_i),
        .f_inst_i   (f_inst_i),
        .f_predict_i(f_predict_i),
        .d_valid_o  (d_valid_o),
        .d_ready_i  (d_ready_i),
        .d_pc_o     (d_pc_o),
        .d_inst_o   (d_inst_o),
        .d_predict_o(d_predict_o)
    );

    // Advance one clock, applying the queue rules to the model.
    task automatic step();
        int sz;
        bit acc;
        int n_out;
        logic [31:0] pc;
        sz    = mq.size();
        acc   = f_valid_i && !flush_i && (DEPTH - sz >= 2);
        n_out = 0;
        if (sz >= 1 && d_ready_i[0]) begin
            n_out = 1;
            if (sz >= 2 && d_ready_i[1]) n_out = 2;
        end
        @(posedge clk);
        if (flush_i) begin
            mq.delete();
        end else begin
            repeat (n_out) void'(mq.pop_front());
            if (acc) begin
                for (int s = 0; s < 2; s++) begin
                    if (f_mask_i[s]) begin
                        pc = {f_pc_i[31:3], 3'b000} + 32'(4 * s);
                        mq.push_back('{pc, f_inst_i[s], f_predict_i[s]});
                    end
                end
                $display("push pc=%h mask=%b occupancy=%0d", f_pc_i, f_mask_i, mq.size());
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        f_valid_i = 1'b0;
        f_mask_i  = 2'b00;
        d_ready_i = 2'b00;
        flush_i   = 1'b0;
    endtask

    task automatic drive_pkt(input logic [31:0] pc, input logic [1:0] mask);
        f_valid_i = 1'b1;
        f_pc_i    = pc;
        f_mask_i  = mask;
        for (int s = 0; s < 2; s++) begin
            f_inst_i[s]           = $urandom;
            f_predict_i[s].taken  = 1'($urandom);
            f_predict_i[s].target = $urandom;
        end
    endtask

    task automatic do_flush();
        idle_inputs();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (d_valid_o !== 2'b00) begin
            errors++; $display("FAIL reset_valid got=%b exp=00", d_valid_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (f_ready_o !== 1'b1 || d_valid_o !== 2'b00) begin
            errors++; $display("FAIL reset_release ready=%b valid=%b exp 1/00", f_ready_o, d_valid_o);
        end
        step();
        checks++;
        if (d_valid_o !== 2'b00 || f_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_idle ready=%b valid=%b exp 1/00", f_ready_o, d_valid_o);
        end
    endtask

    task automatic test_push_pair();
        idle_inputs();
        drive_pkt(32'h1c00_0000, 2'b11);
        f_inst_i[0] = 32'haaaa_0001;
        f_inst_i[1] = 32'hbbbb_0002;
        step();
        idle_inputs();
        #1;
        checks++;
        if (d_valid_o !== 2'b11 || d_pc_o[0] !== 32'h1c00_0000 || d_pc_o[1] !== 32'h1c00_0004) begin
            errors++; $display("FAIL pair_pc valid=%b pc0=%h pc1=%h exp 11/1c000000/1c000004",
                               d_valid_o, d_pc_o[0], d_pc_o[1]);
        end
        checks++;
        if (d_inst_o[0] !== 32'haaaa_0001 || d_inst_o[1] !== 32'hbbbb_0002) begin
            errors++; $display("FAIL pair_inst got=%h/%h exp aaaa0001/bbbb0002", d_inst_o[0], d_inst_o[1]);
        end
        checks++;
        if (d_predict_o[0] !== mq[0].pred || d_predict_o[1] !== mq[1].pred) begin
            errors++; $display("FAIL pair_pred got=%h/%h exp %h/%h",
                               d_predict_o[0], d_predict_o[1], mq[0].pred, mq[1].pred);
        end
    endtask

    task automatic test_compaction();
        do_flush();
        drive_pkt(32'h1c00_0008, 2'b10);
        f_inst_i[1] = 32'h1111_0001;
        step();
        drive_pkt(32'h1c00_0010, 2'b01);
        f_inst_i[0] = 32'h2222_0002;
        step();
        idle_inputs();
        #1;
        checks++;
        if (d_valid_o !== 2'b11 || d_pc_o[0] !== 32'h1c00_000c || d_pc_o[1] !== 32'h1c00_0010) begin
            errors++; $display("FAIL compact_pc valid=%b pc0=%h pc1=%h exp 11/1c00000c/1c000010",
                               d_valid_o, d_pc_o[0], d_pc_o[1]);
        end
        checks++;
        if (d_inst_o[0] !== 32'h1111_0001 || d_inst_o[1] !== 32'h2222_0002) begin
            errors++; $display("FAIL compact_inst got=%h/%h exp 11110001/22220002", d_inst_o[0], d_inst_o[1]);
        end
    endtask

    task automatic test_fill_wrap();
        do_flush();
        drive_pkt(32'h0000_0100, 2'b11);
        step();
        idle_inputs();
        d_ready_i = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            drive_pkt(32'h0000_0200 + 32'(8 * k), 2'b11);
            step();
        end
        idle_inputs();
        #1;
        checks++;
        if (f_ready_o !== 1'b0 || d_valid_o !== 2'b11) begin
            errors++; $display("FAIL full_state ready=%b valid=%b exp 0/11", f_ready_o, d_valid_o);
        end
        d_ready_i = 2'b11;
        step();
        d_ready_i = 2'b00;
        #1;
        checks++;
        if (f_ready_o !== 1'b1) begin
            errors++; $display("FAIL after_drain_ready got=%b exp 1", f_ready_o);
        end
        d_ready_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (d_valid_o !== 2'b11 || d_pc_o[0] !== 32'h0000_0208 + 32'(8 * k)
                || d_pc_o[1] !== 32'h0000_020c + 32'(8 * k)) begin
                errors++; $display("FAIL wrap_order k=%0d valid=%b pc0=%h pc1=%h exp pc0=%h",
                                   k, d_valid_o, d_pc_o[0], d_pc_o[1], 32'h0000_0208 + 32'(8 * k));
            end
            step();
        end
        checks++;
        if (d_valid_o !== 2'b00) begin
            errors++; $display("FAIL wrap_empty got=%b exp 00", d_valid_o);
        end
    endtask

    task automatic test_partial_ready();
        idle_inputs();
        drive_pkt(32'h0000_0300, 2'b11);
        step();
        drive_pkt(32'h0000_0308, 2'b01);
        step();
        idle_inputs();
        d_ready_i = 2'b10;
        step();
        checks++;
        if (d_valid_o !== 2'b11 || d_pc_o[0] !== 32'h0000_0300) begin
            errors++; $display("FAIL ready10 valid=%b pc0=%h exp 11/00000300", d_valid_o, d_pc_o[0]);
        end
        d_ready_i = 2'b01;
        step();
        checks++;
        if (d_valid_o !== 2'b11 || d_pc_o[0] !== 32'h0000_0304 || d_pc_o[1] !== 32'h0000_0308) begin
            errors++; $display("FAIL ready01 valid=%b pc0=%h pc1=%h exp 11/00000304/00000308",
                               d_valid_o, d_pc_o[0], d_pc_o[1]);
        end
        d_ready_i = 2'b11;
        step();
        checks++;
        if (d_valid_o !== 2'b00) begin
            errors++; $display("FAIL ready_drain got=%b exp 00", d_valid_o);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        drive_pkt(32'h0000_0400, 2'b11);
        step();
        drive_pkt(32'h0000_0408, 2'b11);
        step();
        drive_pkt(32'h0000_0410, 2'b01);
        step();
        drive_pkt(32'h0000_0418, 2'b11);
        d_ready_i = 2'b11;
        flush_i   = 1'b1;
        #1;
        checks++;
        if (f_ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_ready got=%b exp 0", f_ready_o);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (d_valid_o !== 2'b00 || f_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_empty valid=%b ready=%b exp 00/1", d_valid_o, f_ready_o);
        end
        step();
        checks++;
        if (d_valid_o !== 2'b00) begin
            errors++; $display("FAIL flush_dropped valid=%b exp 00", d_valid_o);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        drive_pkt(32'h0000_0500, 2'b11);
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        checks++;
        if (d_valid_o !== 2'b00) begin
            errors++; $display("FAIL async_reset valid=%b exp 00", d_valid_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (d_valid_o !== 2'b00 || f_ready_o !== 1'b1) begin
            errors++; $display("FAIL async_release valid=%b ready=%b exp 00/1", d_valid_o, f_ready_o);
        end
    endtask

    task automatic test_random();
        int sz;
        logic [1:0] exp_valid;
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            if ($urandom_range(0, 9) < 7) drive_pkt($urandom, 2'($urandom));
            d_ready_i = 2'($urandom);
            flush_i   = ($urandom_range(0, 49) == 0);
            #1;
            sz = mq.size();
            exp_valid = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
            checks++;
            if (d_valid_o !== exp_valid || f_ready_o !== (!flush_i && (DEPTH - sz >= 2))) begin
                errors++; $display("FAIL rand_ctrl n=%0d valid=%b exp=%b ready=%b occ=%0d",
                                   n, d_valid_o, exp_valid, f_ready_o, sz);
            end
            for (int s = 0; s < 2; s++) begin
                if (s < sz) begin
                    checks++;
                    if (d_pc_o[s] !== mq[s].pc || d_inst_o[s] !== mq[s].inst
                        || d_predict_o[s] !== mq[s].pred) begin
                        errors++; $display("FAIL rand_data n=%0d slot=%0d pc=%h/%h inst=%h/%h pred=%h/%h",
                                           n, s, d_pc_o[s], mq[s].pc, d_inst_o[s], mq[s].inst,
                                           d_predict_o[s], mq[s].pred);
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_push_pair();
        test_compaction();
        test_fill_wrap();
        test_partial_ready();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
